// File: rtl/saturnin_sbox_layer.sv
// Iterative Saturnin S-box layer: sigma0 on even nibbles, sigma1 on odd nibbles, LANES nibbles per beat.
// Latency: BEATS busy cycles after the accepting edge, then held in DONE until out_ready; BEATS = NIBBLES/LANES.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE while out_ready is low.
// Optional macro SATURNIN_SBOX_INV_EN adds an inv port selecting the inverse tables per block.
module saturnin_sbox_layer #(
  parameter int NIBBLES = 64,
  parameter int LANES   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
`ifdef SATURNIN_SBOX_INV_EN
  input  logic                 inv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_count
);

  localparam int BEATS  = NIBBLES / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LANE_W = 4 * LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Even LANES keeps every beat base on an even nibble, so lane parity equals absolute nibble parity.
  if ((LANES < 2) || ((LANES % 2) != 0) || ((NIBBLES % LANES) != 0)) begin : g_param_err
    $error("saturnin_sbox_layer: LANES must be even and divide NIBBLES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward S-box for even nibble positions.
  function automatic logic [3:0] sigma0(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h6;  4'h2: y = 4'hE;  4'h3: y = 4'h1;
      4'h4: y = 4'hF;  4'h5: y = 4'h4;  4'h6: y = 4'h7;  4'h7: y = 4'hD;
      4'h8: y = 4'h9;  4'h9: y = 4'h8;  4'hA: y = 4'hC;  4'hB: y = 4'h5;
      4'hC: y = 4'h2;  4'hD: y = 4'hA;  4'hE: y = 4'h3;  default: y = 4'hB;
    endcase
    return y;
  endfunction

  // Forward S-box for odd nibble positions.
  function automatic logic [3:0] sigma1(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h9;  4'h2: y = 4'hD;  4'h3: y = 4'h2;
      4'h4: y = 4'hF;  4'h5: y = 4'h1;  4'h6: y = 4'hB;  4'h7: y = 4'h7;
      4'h8: y = 4'h6;  4'h9: y = 4'h4;  4'hA: y = 4'h5;  4'hB: y = 4'h3;
      4'hC: y = 4'h8;  4'hD: y = 4'hC;  4'hE: y = 4'hA;  default: y = 4'hE;
    endcase
    return y;
  endfunction

`ifdef SATURNIN_SBOX_INV_EN
  // Inverse of sigma0.
  function automatic logic [3:0] sigma0_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h3;  4'h2: y = 4'hC;  4'h3: y = 4'hE;
      4'h4: y = 4'h5;  4'h5: y = 4'hB;  4'h6: y = 4'h1;  4'h7: y = 4'h6;
      4'h8: y = 4'h9;  4'h9: y = 4'h8;  4'hA: y = 4'hD;  4'hB: y = 4'hF;
      4'hC: y = 4'hA;  4'hD: y = 4'h7;  4'hE: y = 4'h2;  default: y = 4'h4;
    endcase
    return y;
  endfunction

  // Inverse of sigma1.
  function automatic logic [3:0] sigma1_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h5;  4'h2: y = 4'h3;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'hA;  4'h6: y = 4'h8;  4'h7: y = 4'h7;
      4'h8: y = 4'hC;  4'h9: y = 4'h1;  4'hA: y = 4'hE;  4'hB: y = 4'h6;
      4'hC: y = 4'hD;  4'hD: y = 4'h2;  4'hE: y = 4'hF;  default: y = 4'h4;
    endcase
    return y;
  endfunction
`endif

  state_t                 state_q, state_d;
  logic [4*NIBBLES-1:0]   work_q, work_d;
  logic [BEAT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]       blk_q, blk_d;
  logic [LANE_W-1:0]      lane_in;
  logic [LANE_W-1:0]      lane_out;
`ifdef SATURNIN_SBOX_INV_EN
  logic                   inv_q, inv_d;
`endif

  // Slice of the working register handled in the current beat.
  always_comb begin
    lane_in = work_q[cnt_q * LANE_W +: LANE_W];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    if ((g % 2) == 0) begin : g_even
`ifdef SATURNIN_SBOX_INV_EN
      assign lane_out[4*g +: 4] = inv_q ? sigma0_inv(lane_in[4*g +: 4]) : sigma0(lane_in[4*g +: 4]);
`else
      assign lane_out[4*g +: 4] = sigma0(lane_in[4*g +: 4]);
`endif
    end else begin : g_odd
`ifdef SATURNIN_SBOX_INV_EN
      assign lane_out[4*g +: 4] = inv_q ? sigma1_inv(lane_in[4*g +: 4]) : sigma1(lane_in[4*g +: 4]);
`else
      assign lane_out[4*g +: 4] = sigma1(lane_in[4*g +: 4]);
`endif
    end
  end

  // Next-state logic: capture in IDLE, substitute one slice per BUSY cycle, hand off in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
`ifdef SATURNIN_SBOX_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef SATURNIN_SBOX_INV_EN
          inv_d   = inv;
`endif
        end
      end
      BUSY: begin
        work_d[cnt_q * LANE_W +: LANE_W] = lane_out;
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          blk_d   = blk_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
`ifdef SATURNIN_SBOX_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
`ifdef SATURNIN_SBOX_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Outputs decode directly from the state register; out_data keeps the last result until the next capture.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;
  assign blk_count = blk_q;

endmodule

// File: tb/tb_saturnin_sbox_layer.sv
// Bench for saturnin_sbox_layer: three instances (LANES 16, 64, 2) share stimulus.
// Expected states are queued at send time and checked by a per-instance monitor on handshake.
// The LANES=2 instance uses a 3-bit block counter so wrap-around is exercised.
module tb_saturnin_sbox_layer;
  localparam int W = 256;

  logic clk;
  logic rst;
  logic in_valid;
  logic [W-1:0] in_data;
  logic out_ready;
`ifdef SATURNIN_SBOX_INV_EN
  logic inv;
`endif

  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [W-1:0] out_data  [3];
  logic [15:0]  blk0, blk1;
  logic [2:0]   blk2;
  logic [15:0]  blk [3];

  assign blk[0] = blk0;
  assign blk[1] = blk1;
  assign blk[2] = {13'd0, blk2};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int rd [3]   = '{0, 0, 0};
  int beats_of [3] = '{4, 1, 32};
  logic [15:0] mask_of [3] = '{16'hFFFF, 16'hFFFF, 16'h0007};
  logic [15:0] exp_cnt [3];
  logic         prev_v [3];
  logic         prev_r [3];
  logic [W-1:0] prev_d [3];
  logic [W-1:0] exp_q [$];
  bit rnd_rdy = 0;

  saturnin_sbox_layer #(.NIBBLES(64), .LANES(16), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
`ifdef SATURNIN_SBOX_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .busy(busy[0]), .blk_count(blk0));

  saturnin_sbox_layer #(.NIBBLES(64), .LANES(64), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
`ifdef SATURNIN_SBOX_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .busy(busy[1]), .blk_count(blk1));

  saturnin_sbox_layer #(.NIBBLES(64), .LANES(2), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
`ifdef SATURNIN_SBOX_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
    .busy(busy[2]), .blk_count(blk2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference S-box layer built from the published tables; inverse found by table search.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic iv);
    logic [3:0] s0 [16];
    logic [3:0] s1 [16];
    logic [3:0] x, y, t;
    logic [W-1:0] r;
    s0 = '{4'h0, 4'h6, 4'hE, 4'h1, 4'hF, 4'h4, 4'h7, 4'hD, 4'h9, 4'h8, 4'hC, 4'h5, 4'h2, 4'hA, 4'h3, 4'hB};
    s1 = '{4'h0, 4'h9, 4'hD, 4'h2, 4'hF, 4'h1, 4'hB, 4'h7, 4'h6, 4'h4, 4'h5, 4'h3, 4'h8, 4'hC, 4'hA, 4'hE};
    r = '0;
    for (int k = 0; k < 64; k++) begin
      x = d[4*k +: 4];
      y = 4'h0;
      if (!iv) begin
        y = (k % 2 == 1) ? s1[x] : s0[x];
      end else begin
        for (int j = 0; j < 16; j++) begin
          t = (k % 2 == 1) ? s1[j] : s0[j];
          if (t == x) y = 4'(j);
        end
      end
      r[4*k +: 4] = y;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_state();
    logic [W-1:0] d;
    for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom();
    return d;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        exp_cnt[i] = '0;
        prev_v[i]  = 1'b0;
        prev_r[i]  = 1'b0;
        prev_d[i]  = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("busy_vs_ready u%0d", i), W'(busy[i]), W'(!in_ready[i]));
        check($sformatf("blk_count u%0d", i), W'(blk[i]), W'(exp_cnt[i]));
        if (out_valid[i] && !prev_v[i])
          check($sformatf("latency u%0d", i), W'(cyc - acc_cyc + 1), W'(beats_of[i] + 1));
        if (out_valid[i])
          check($sformatf("in_ready_in_done u%0d", i), W'(in_ready[i]), W'(0));
        if (out_valid[i] && prev_v[i] && !prev_r[i])
          check($sformatf("hold_stable u%0d", i), out_data[i], prev_d[i]);
        if (out_valid[i] && out_ready) begin
          check($sformatf("sb_avail u%0d", i), W'(rd[i] < exp_q.size()), W'(1));
          if (rd[i] < exp_q.size()) begin
            check($sformatf("out_data u%0d", i), out_data[i], exp_q[rd[i]]);
            rd[i]++;
          end
          exp_cnt[i] = (exp_cnt[i] + 16'd1) & mask_of[i];
        end
        prev_v[i] = out_valid[i];
        prev_r[i] = out_ready;
        prev_d[i] = out_data[i];
      end
    end
  end

  task automatic wait_all_ready();
    int t = 0;
    while (!(in_ready[0] && in_ready[1] && in_ready[2]) && t < 400) begin
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    check("wait_ready", W'(in_ready[0] && in_ready[1] && in_ready[2]), W'(1));
  endtask

  // Present one state for a single cycle; accept happens at the next edge.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] e, input logic iv);
    wait_all_ready();
    in_valid = 1'b1;
    in_data  = d;
`ifdef SATURNIN_SBOX_INV_EN
    inv      = iv;
`else
    if (iv) $display("note: inverse request ignored in forward-only build");
`endif
    acc_cyc  = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rnd_state();
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (!((rd[0] == exp_q.size()) && (rd[1] == exp_q.size()) && (rd[2] == exp_q.size())
             && in_ready[0] && in_ready[1] && in_ready[2]) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", W'(t < 400), W'(1));
  endtask

  initial begin
    logic [W-1:0] d, e, f;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SATURNIN_SBOX_INV_EN
    inv = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", W'(in_ready[i]), W'(1));
      check("rst_out_valid", W'(out_valid[i]), W'(0));
      check("rst_busy", W'(busy[i]), W'(0));
      check("rst_blk_count", W'(blk[i]), W'(0));
      check("rst_out_data", out_data[i], '0);
    end
    rst = 1'b0;

    // Abandon a block with reset while the LANES=16 instance is in its third beat.
    d = rnd_state();
    send(d, model(d, 1'b0), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_rst", W'(busy[0]), W'(1));
    rst = 1'b1;
    exp_q.delete();
    rd = '{0, 0, 0};
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_in_ready", W'(in_ready[i]), W'(1));
      check("midrst_out_valid", W'(out_valid[i]), W'(0));
      check("midrst_blk_count", W'(blk[i]), W'(0));
    end

    // All-zero state with out_ready held high.
    out_ready = 1'b1;
    send('0, '0, 1'b0);
    drain();
    check("zero_blk_count", W'(blk[0]), W'(1));

    // Every nibble 0x1.
    d = {64{4'h1}};
    send(d, {32{8'h96}}, 1'b0);
    drain();

    // Every nibble 0xF with the consumer stalled for ten cycles.
    out_ready = 1'b0;
    d = {64{4'hF}};
    send(d, {32{8'hEB}}, 1'b0);
    begin
      int t = 0;
      while (!out_valid[0] && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("wait_valid", W'(out_valid[0]), W'(1));
    end
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_in_ready", W'(in_ready[0]), W'(0));
      check("stall_out_valid", W'(out_valid[0]), W'(1));
      check("stall_out_data", out_data[0], {32{8'hEB}});
      check("stall_blk_count", W'(blk[0]), W'(2));
    end
    drain();
    check("release_blk_count", W'(blk[0]), W'(3));

    // Nibble k = k mod 16.
    for (int k = 0; k < 64; k++) d[4*k +: 4] = 4'(k);
    e = model(d, 1'b0);
    send(d, e, 1'b0);
    drain();
    check("out_data_kept", out_data[0], e);

    // Random states with a randomly stalling consumer.
    rnd_rdy = 1'b1;
    repeat (6) begin
      d = rnd_state();
      send(d, model(d, 1'b0), 1'b0);
    end
    rnd_rdy = 1'b0;
    drain();

`ifdef SATURNIN_SBOX_INV_EN
    // Inverse tables: every nibble 0x6 maps to 1 on even and 8 on odd positions.
    send({64{4'h6}}, {32{8'h81}}, 1'b1);
    drain();
    // Forward then inverse returns the original state.
    repeat (3) begin
      d = rnd_state();
      f = model(d, 1'b0);
      send(d, f, 1'b0);
      send(f, d, 1'b1);
    end
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
